// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light timing engine.
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } delay_state_t;

  localparam logic [6:0] LFSR_SEED = 7'h01;
  localparam int LFSR_TAP_A = 6;
  localparam int LFSR_TAP_B = 2;

endpackage

// File: rtl/lfsr_7.sv
// Free-running 7-bit Fibonacci LFSR, x^7 + x^3 + 1.
module lfsr_7
  import f1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= LFSR_SEED;
    else     q <= {q[5:0], q[LFSR_TAP_A] ^ q[LFSR_TAP_B]};
  end

endmodule

// File: rtl/f1_timer_engine.sv
// Tick divider and random-delay engine serving the start-light sequencer.
module f1_timer_engine
  import f1_pkg::*;
#(
  parameter int TICK_N = 24,
  parameter int UNIT_N = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       cmd_seq,
  input  logic       cmd_delay,
  output logic       tick,
  output logic       timeOut,
  output logic [6:0] delay_value,
  output logic       busy
);

  localparam int TW = $clog2(TICK_N);
  localparam int UW = (UNIT_N > 1) ? $clog2(UNIT_N) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_N - 1);
  localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_N - 1);

  logic [6:0] lfsr_q;

  lfsr_7 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  logic [TW-1:0] tick_cnt;
  logic          tick_zero;

  assign tick_zero = (tick_cnt == '0);
  assign tick      = cmd_seq & en & tick_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           tick_cnt <= TICK_LAST;
    else if (!cmd_seq) tick_cnt <= TICK_LAST;
    else if (en)       tick_cnt <= tick_zero ? TICK_LAST
                                             : tick_cnt - TW'(1);
  end

  logic cmd_delay_q;
  logic start;

  assign start = cmd_delay & ~cmd_delay_q;

  delay_state_t  state, state_d;
  logic [6:0]    dly_cnt, dly_d, dv_d;
  logic [UW-1:0] unit_cnt, unit_d;

  always_comb begin
    state_d = state;
    dly_d   = dly_cnt;
    unit_d  = unit_cnt;
    dv_d    = delay_value;
    unique case (state)
      IDLE: begin
        if (start) begin
          dv_d    = lfsr_q;
          dly_d   = lfsr_q;
          unit_d  = UNIT_LAST;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (en) begin
          if (unit_cnt == '0) begin
            if (dly_cnt == 7'd1) begin
              state_d = DONE;
            end else begin
              dly_d  = dly_cnt - 7'd1;
              unit_d = UNIT_LAST;
            end
          end else begin
            unit_d = unit_cnt - UW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dly_cnt     <= '0;
      unit_cnt    <= '0;
      delay_value <= '0;
      cmd_delay_q <= 1'b0;
    end else begin
      state       <= state_d;
      dly_cnt     <= dly_d;
      unit_cnt    <= unit_d;
      delay_value <= dv_d;
      cmd_delay_q <= cmd_delay;
    end
  end

  // timeOut is a pure decode of the registered state, so it is glitch-free
  assign timeOut = (state == DONE);
  assign busy    = (state != IDLE);

endmodule
